// File: rtl/matrix_scan_driver_if.sv
`default_nettype none
// ============================================================================
// matrix_scan_driver_if : pixel write port and shift-register connector bundle
// Rev 1.0
// ============================================================================
interface matrix_scan_driver_if #(
   parameter int ROWS = 16,
   parameter int COLS = 16,
   parameter int BPP  = 2
);
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

   logic           wr_en;
   logic [RW-1:0]  wr_row;
   logic [CW-1:0]  wr_col;
   logic [BPP-1:0] wr_data;
   logic           swap_req;
   logic           frame_start;
   logic           sclk;
   logic           serial_data;
   logic           rclk;
   logic           clear_n;

   modport master (
      output wr_en, wr_row, wr_col, wr_data, swap_req,
      input  frame_start, sclk, serial_data, rclk, clear_n
   );

   modport slave (
      input  wr_en, wr_row, wr_col, wr_data, swap_req,
      output frame_start, sclk, serial_data, rclk, clear_n
   );
endinterface
`default_nettype wire

// File: rtl/matrix_scan_driver.sv
`default_nettype none
// ============================================================================
// matrix_scan_driver : row-multiplexed, binary-threshold grey-scale driver for
// cascaded 74HC595 LED boards; optional MATRIX_SCAN_DOUBLE_BUFFER_EN. Rev 1.0
// ============================================================================
module matrix_scan_driver #(
   parameter int ROWS    = 16,
   parameter int COLS    = 16,
   parameter int BPP     = 2,
   parameter int CLK_DIV = 100
) (
   input  wire logic           clk,
   input  wire logic           rst_n,
   matrix_scan_driver_if.slave bus
);
   localparam int NSUB  = (1 << BPP) - 1;
   localparam int NBITS = COLS + ROWS;
   localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int KW    = $clog2(NBITS);
   localparam int DW    = $clog2(2 * CLK_DIV);

   typedef enum logic [0:0] {
      ST_SHIFT = 1'b0,
      ST_LATCH = 1'b1
   } state_t;

   state_t         state_q;
   logic [DW-1:0]  div_q;
   logic [KW-1:0]  bit_q;
   logic [RW-1:0]  row_q;
   logic [BPP-1:0] sub_q;
   logic           sclk_q;
   logic           sdata_q;
   logic           rclk_q;
   logic           clear_n_q;
   logic           frame_start_q;

   logic           frame_start_d;
   logic [CW-1:0]  col_d;
   logic [RW-1:0]  cat_row_d;
   logic [BPP-1:0] pix_d;
   logic           data_d;
   logic           wr_ok_d;

`ifdef MATRIX_SCAN_DOUBLE_BUFFER_EN
   logic [BPP-1:0] pix_q [2][ROWS][COLS];
   logic           bank_q;
   logic           pending_q;
   logic           swap_d;
   logic           front_d;

   // The exchange must already steer the very first anode read of the frame.
   assign swap_d  = frame_start_d && pending_q;
   assign front_d = bank_q ^ swap_d;
   assign pix_d   = pix_q[front_d][row_q][col_d];
`else
   logic [BPP-1:0] pix_q [ROWS][COLS];
   logic           unused_swap_req;

   assign unused_swap_req = bus.swap_req;
   assign pix_d           = pix_q[row_q][col_d];
`endif

   always_comb begin
      frame_start_d = (state_q == ST_SHIFT) && (div_q == '0) && (bit_q == '0)
                      && (row_q == '0) && (sub_q == '0);
      col_d         = CW'(COLS - 1 - int'(bit_q));
      cat_row_d     = RW'(int'(bit_q) - COLS);
      data_d        = (int'(bit_q) < COLS) ? (pix_d > sub_q) : (cat_row_d != row_q);
      wr_ok_d       = bus.wr_en && (int'(bus.wr_row) < ROWS) && (int'(bus.wr_col) < COLS);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_SHIFT;
         div_q         <= '0;
         bit_q         <= '0;
         row_q         <= '0;
         sub_q         <= '0;
         sclk_q        <= 1'b0;
         sdata_q       <= 1'b0;
         rclk_q        <= 1'b0;
         clear_n_q     <= 1'b0;
         frame_start_q <= 1'b0;
         for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
`ifdef MATRIX_SCAN_DOUBLE_BUFFER_EN
               pix_q[0][r][c] <= '0;
               pix_q[1][r][c] <= '0;
`else
               pix_q[r][c] <= '0;
`endif
            end
         end
`ifdef MATRIX_SCAN_DOUBLE_BUFFER_EN
         bank_q    <= 1'b0;
         pending_q <= 1'b0;
`endif
      end else begin
         clear_n_q     <= 1'b1;
         frame_start_q <= frame_start_d;

`ifdef MATRIX_SCAN_DOUBLE_BUFFER_EN
         if (wr_ok_d) pix_q[~front_d][bus.wr_row][bus.wr_col] <= bus.wr_data;
         if (swap_d) begin
            bank_q    <= ~bank_q;
            pending_q <= bus.swap_req;
         end else if (bus.swap_req) begin
            pending_q <= 1'b1;
         end
`else
         if (wr_ok_d) pix_q[bus.wr_row][bus.wr_col] <= bus.wr_data;
`endif

         case (state_q)
            ST_SHIFT: begin
               rclk_q <= 1'b0;
               sclk_q <= (div_q >= DW'(CLK_DIV));
               if (div_q == '0) sdata_q <= data_d;
            end
            ST_LATCH: begin
               rclk_q  <= 1'b1;
               sclk_q  <= 1'b0;
               sdata_q <= 1'b0;
            end
         endcase

         if (div_q == DW'(2 * CLK_DIV - 1)) begin
            div_q <= '0;
            if (state_q == ST_SHIFT) begin
               if (bit_q == KW'(NBITS - 1)) begin
                  bit_q   <= '0;
                  state_q <= ST_LATCH;
               end else begin
                  bit_q <= bit_q + 1'b1;
               end
            end else begin
               state_q <= ST_SHIFT;
               if (row_q == RW'(ROWS - 1)) begin
                  row_q <= '0;
                  sub_q <= (sub_q == BPP'(NSUB - 1)) ? '0 : sub_q + 1'b1;
               end else begin
                  row_q <= row_q + 1'b1;
               end
            end
         end else begin
            div_q <= div_q + 1'b1;
         end
      end
   end

   assign bus.frame_start = frame_start_q;
   assign bus.sclk        = sclk_q;
   assign bus.serial_data = sdata_q;
   assign bus.rclk        = rclk_q;
   assign bus.clear_n     = clear_n_q;
endmodule
`default_nettype wire
